sierpinski_lfsr_gen: RTL and testbench
======================================

# sierpinski_lfsr_gen

Parametrised pattern-generator core for the Sierpinski/LFSR Tiny Tapeout design, generalising the fixed 14-bit generator to any width from 4 to 32 bits. It runs as a Galois LFSR or as a rule-90 cellular automaton, with either zero or wrap-around boundaries; rule 90 from a single seed bit draws the Sierpinski triangle. Each state word streams out over a valid/ready handshake, for a programmed step count or free-running. It sits between the `tt_um_` top-level pin mapping and the output serialiser.

## Interface
- `WIDTH`, 14: state width, legal range 4..32.
- `POLY`, 14'h002B: Galois feedback mask of the polynomial's low terms. The default is x^14+x^5+x^3+x+1.
- `SEED_RST`, 14'h0080: state value at reset.
- `CNT_W`, 16: width of the step counter.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: global enable. When low, all registers hold.
- `load` in 1: load `seed` into the state register.
- `seed` in WIDTH: seed value.
- `mode` in 2: 0 = LFSR, 1 = rule-90 with zero boundary, 2 = rule-90 with wrap-around, 3 = reserved.
- `start` in 1: begin a run.
- `stop` in 1: abort a run.
- `num_steps` in CNT_W: number of words to emit. 0 = free-run.
- `out_data` out WIDTH: current state word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts the word.
- `busy` out 1: FSM is in RUN.
- `done` out 1: one-cycle pulse when a counted run completes.
- `period_hit` out 1: one-cycle pulse when the state returns to the run's starting seed.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- All behaviour below applies only in cycles with `ena`=1.
- Next-state function by mode:
  - Mode 0: next = ((s<<1) & mask) ^ (s[W-1] ? POLY : 0).
  - Mode 1: next[i] = s[i-1] ^ s[i+1], with out-of-range bits read as 0.
  - Mode 2: same as mode 1, but indices wrap modulo WIDTH.
- Load, in IDLE or DONE: state <= `seed`.
  - Lock-up guard: if `seed`==0 and `mode`==0, the state loads 1 instead.
  - `load` is ignored in RUN.
- Start, in IDLE or DONE, with `mode`!=3:
  - Latch the mode, latch `remaining` <= `num_steps`, and latch `run_seed` <= the state after any same-cycle load.
  - Go to RUN.
  - If `load` and `start` are asserted together, the new seed is the run seed.
  - A start with `mode`==3 is ignored and the FSM stays in its current state.
- RUN:
  - `out_valid`=1 and `out_data` = state.
  - The first word emitted is the seed itself.
  - On each handshake (`out_valid`&`out_ready`): state <= next, and `remaining` decrements when nonzero.
  - Without a handshake, state and `out_data` hold stable.
- Counted run: the handshake that takes `remaining` from 1 to 0 goes to DONE. The run therefore emits exactly `num_steps` words.
- Free run (`num_steps`=0): continues until `stop`.
- Stop in RUN: go to IDLE at the next edge with no `done` pulse.
  - A handshake in the same cycle still completes and advances the state.
  - `stop` outside RUN has no effect.
- DONE lasts one cycle with `done`=1, then goes to IDLE. A `start` in DONE goes straight to RUN.
- `period_hit`: registered pulse in the cycle after a handshake whose next state equals `run_seed`. Reported in mode 0 only.
- The state register persists across runs, so the next start continues from the last state unless a load occurs.

## Timing
- Reset values: state = `SEED_RST`, `out_data` = `SEED_RST`, and `out_valid`, `busy`, `done`, `period_hit` all 0.
- Reset is asynchronous and may assert mid-run. The FSM returns to IDLE immediately and all outputs take their reset values.
- Start latency: `start` at edge N gives `out_valid`=1 from after edge N.
- Throughput: one word per cycle while `out_ready`=1.
- After the final handshake at edge M: after edge M, `out_valid`=0 and `done`=1 for exactly one cycle.
- `out_data` is a registered output driven directly from the state register, with no combinational path from the inputs.
- `out_valid` never drops without a handshake, except on `stop`, `ena` low (output held, handshake blocked), or reset.

## Test plan
- Rule 90, zero boundary: reset, start with `mode`=1, `num_steps`=4, `out_ready`=1.
  - Required words: 0x0080, 0x0140, 0x0220, 0x0550.
  - Then `done` pulses once and `busy` drops.
- Wrap-around vs zero boundary:
  - Load 0x0001 with `mode`=2, one step: words 0x0001, 0x2002.
  - Same with `mode`=1: words 0x0001, 0x0002.
- LFSR:
  - Load 0x2000 with `mode`=0, 2 steps: words 0x2000, 0x002B.
  - Load 0 with `mode`=0: first word is 0x0001.
- LFSR period: seed 1, free-run with `out_ready`=1.
  - `period_hit` first pulses after exactly 16383 handshakes.
  - Then `stop`: `busy` drops and there is no `done` pulse.
- Backpressure: toggle `out_ready` randomly on a 100-step rule-90 run.
  - Every word must match the reference model, with no skipped or duplicated words.
  - `out_data` stays stable while stalled.
  - Lowering `ena` mid-run freezes everything.
- Reset and ignored controls:
  - Assert `rst_n` low mid-run: outputs go to their reset values asynchronously, and a subsequent start behaves as after power-on.
  - Start with `mode`=3 is ignored.
  - `load` during RUN is ignored.

Source files
------------

// File: rtl/sierpinski_lfsr_gen.sv
// Pattern generator: Galois LFSR or rule-90 cellular automaton, streamed over valid/ready.
// Latency: first word (the seed) is valid the cycle after start; then one word per handshake.
// Backpressure: out_ready low (or ena low) holds state and out_data stable; out_valid stays up.
module sierpinski_lfsr_gen #(
  parameter int unsigned      WIDTH    = 14,
  parameter logic [WIDTH-1:0] POLY     = 14'h002B,
  parameter logic [WIDTH-1:0] SEED_RST = 14'h0080,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_steps,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             period_hit
);

  localparam logic [1:0] MODE_LFSR = 2'd0;
  localparam logic [1:0] MODE_WRAP = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] seed;
  } run_ctx_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  run_ctx_t         run_q, run_d;
  logic             hit_q, hit_d;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] adv;

  // Rule 90 is built from a copy of the state padded with one boundary cell at each
  // end, so bit i of the result is simply ext[i] ^ ext[i+2].
  function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] s,
                                               input logic [1:0]       m);
    logic [WIDTH+1:0] ext;
    logic [WIDTH-1:0] r;
    ext = '0;
    r   = '0;
    if (m == MODE_LFSR) begin
      r = (s << 1) ^ (s[WIDTH-1] ? POLY : '0);
    end else begin
      ext[WIDTH:1] = s;
      if (m == MODE_WRAP) begin
        ext[0]       = s[WIDTH-1];
        ext[WIDTH+1] = s[0];
      end
      r = ext[WIDTH-1:0] ^ ext[WIDTH+1:2];
    end
    return r;
  endfunction

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    run_d    = run_q;
    hit_d    = 1'b0;
    // An all-zero LFSR never leaves zero, so a zero seed in LFSR mode becomes 1.
    load_val = ((seed == '0) && (mode == MODE_LFSR)) ? WIDTH'(1) : seed;
    adv      = step_fn(state_q, run_q.mode);

    case (fsm_q)
      S_IDLE, S_DONE: begin
        if (fsm_q == S_DONE) fsm_d = S_IDLE;
        if (load) state_d = load_val;
        if (start && (mode != MODE_RSVD)) begin
          fsm_d           = S_RUN;
          run_d.mode      = mode;
          run_d.remaining = num_steps;
          run_d.seed      = load ? load_val : state_q;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          state_d = adv;
          if (run_q.remaining != '0) run_d.remaining = run_q.remaining - CNT_W'(1);
          if (run_q.remaining == CNT_W'(1)) fsm_d = S_DONE;
          hit_d = (run_q.mode == MODE_LFSR) && (adv == run_q.seed);
        end
        // Abort wins over completion: a stop never produces a done pulse.
        if (stop) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
    end else if (ena) begin
      fsm_q <= fsm_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED_RST;
      run_q   <= '0;
      hit_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      run_q   <= run_d;
      hit_q   <= hit_d;
    end
  end

  assign out_data   = state_q;
  assign out_valid  = (fsm_q == S_RUN);
  assign busy       = (fsm_q == S_RUN);
  assign done       = (fsm_q == S_DONE);
  assign period_hit = hit_q;

endmodule

// File: tb/tb_sierpinski_lfsr_gen.sv
// Directed bench for sierpinski_lfsr_gen: rule-90 and LFSR sequences, period, backpressure,
// enable freeze, async reset and ignored controls.
module tb_sierpinski_lfsr_gen;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        load;
  logic [13:0] seed;
  logic [1:0]  mode;
  logic        start;
  logic        stop;
  logic [15:0] num_steps;
  logic [13:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        period_hit;

  int tests;
  int fails;

  sierpinski_lfsr_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .load       (load),
    .seed       (seed),
    .mode       (mode),
    .start      (start),
    .stop       (stop),
    .num_steps  (num_steps),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .period_hit (period_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rule 90 with zero boundary, written as shift-and-xor on the whole word.
  function automatic logic [13:0] r90z(input logic [13:0] s);
    return (s << 1) ^ (s >> 1);
  endfunction

  // Load+start a two-word counted run and check both words and the done pulse.
  task automatic two_words(input string tag, input logic [13:0] sd, input logic [1:0] md,
                           input logic [13:0] w0, input logic [13:0] w1);
    load = 1'b1; seed = sd; mode = md; num_steps = 16'd2; start = 1'b1; out_ready = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    chk({tag, "_w0"}, 32'(out_data), 32'(w0));
    step();
    chk({tag, "_w1"}, 32'(out_data), 32'(w1));
    step();
    chk({tag, "_done"}, 32'(done), 32'd1);
    step();
  endtask

  initial begin
    logic [13:0] exp_w;
    logic [13:0] held;
    logic [13:0] t1_words [4];
    int          n;
    int          words;
    int          cyc;
    logic        rdy;
    logic        frozen;

    tests = 0; fails = 0;
    rst_n = 1'b0; ena = 1'b1; load = 1'b0; seed = '0; mode = 2'd0;
    start = 1'b0; stop = 1'b0; num_steps = '0; out_ready = 1'b0;
    t1_words[0] = 14'h0080; t1_words[1] = 14'h0140;
    t1_words[2] = 14'h0220; t1_words[3] = 14'h0550;

    // Reset state
    repeat (3) step();
    chk("rst_data",  32'(out_data),   32'h0080);
    chk("rst_valid", 32'(out_valid),  32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_done",  32'(done),       32'd0);
    chk("rst_hit",   32'(period_hit), 32'd0);
    rst_n = 1'b1;
    step();

    // Rule 90 zero boundary from the reset seed, four words
    mode = 2'd1; num_steps = 16'd4; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("r90_valid", 32'(out_valid), 32'd1);
      chk("r90_word",  32'(out_data),  32'(t1_words[k]));
      step();
    end
    chk("r90_done",    32'(done),      32'd1);
    chk("r90_valid_lo",32'(out_valid), 32'd0);
    chk("r90_busy_lo", 32'(busy),      32'd0);
    step();
    chk("r90_done_pulse", 32'(done), 32'd0);

    // Boundary handling and LFSR feedback
    two_words("wrap", 14'h0001, 2'd2, 14'h0001, 14'h2002);
    two_words("zero", 14'h0001, 2'd1, 14'h0001, 14'h0002);
    two_words("lfsr", 14'h2000, 2'd0, 14'h2000, 14'h002B);

    // Zero seed in LFSR mode loads 1
    load = 1'b1; seed = 14'h0000; mode = 2'd0;
    step();
    load = 1'b0;
    chk("lfsr_zero_guard", 32'(out_data), 32'h0001);

    // Free-running LFSR from seed 1 must revisit the seed after 2^14-1 steps
    num_steps = 16'd0; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("period_busy", 32'(busy), 32'd1);
    n = 0;
    while (!period_hit && n < 20000) begin
      step();
      n++;
    end
    chk("period_len",  32'(n),        32'd16383);
    chk("period_data", 32'(out_data), 32'h0001);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy",  32'(busy),       32'd0);
    chk("stop_valid", 32'(out_valid),  32'd0);
    chk("stop_done",  32'(done),       32'd0);
    chk("stop_adv",   32'(out_data),   32'h0002);
    chk("stop_hit",   32'(period_hit), 32'd0);
    step();
    chk("stop_done2", 32'(done), 32'd0);

    // Random backpressure on a 100-word rule-90 run, with an enable freeze halfway
    load = 1'b1; seed = 14'h0080; mode = 2'd1; num_steps = 16'd100; start = 1'b1; out_ready = 1'b0;
    step();
    load = 1'b0; start = 1'b0;
    exp_w = 14'h0080; words = 0; cyc = 0; frozen = 1'b0;
    while (words < 100 && cyc < 2000) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data),  32'(exp_w));
      if (words == 50 && !frozen) begin
        frozen = 1'b1;
        ena = 1'b0; out_ready = 1'b1;
        held = out_data;
        repeat (3) begin
          step();
          chk("ena_data", 32'(out_data), 32'(held));
          chk("ena_busy", 32'(busy),     32'd1);
        end
        ena = 1'b1;
      end
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      step();
      cyc++;
      if (rdy) begin
        exp_w = r90z(exp_w);
        words++;
      end
    end
    chk("bp_words", 32'(words),     32'd100);
    chk("bp_done",  32'(done),      32'd1);
    chk("bp_vlo",   32'(out_valid), 32'd0);
    step();

    // Asynchronous reset mid-run, then a run identical to the one after power-on
    mode = 2'd1; num_steps = 16'd0; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #2;
    chk("arst_data",  32'(out_data),   32'h0080);
    chk("arst_valid", 32'(out_valid),  32'd0);
    chk("arst_busy",  32'(busy),       32'd0);
    chk("arst_hit",   32'(period_hit), 32'd0);
    step();
    rst_n = 1'b1;
    mode = 2'd1; num_steps = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_w0", 32'(out_data), 32'h0080);
    step();
    chk("post_rst_w1", 32'(out_data), 32'h0140);
    step();
    chk("post_rst_done", 32'(done), 32'd1);
    step();

    // Reserved mode start is ignored
    mode = 2'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("rsvd_busy",  32'(busy),      32'd0);
    chk("rsvd_valid", 32'(out_valid), 32'd0);

    // Load while running is ignored
    load = 1'b1; seed = 14'h0100; mode = 2'd1; num_steps = 16'd3; start = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0; seed = 14'h3FFF;
    step();
    load = 1'b0;
    chk("run_load_data", 32'(out_data), 32'h0100);
    chk("run_load_busy", 32'(busy),     32'd1);
    out_ready = 1'b1;
    step();
    chk("run_load_next", 32'(out_data), 32'h0280);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
